uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_baud_counter.sv | 40 ++++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: FSM state encoding and default bit time
// Purpose: state encoding and default CLKS_PER_BIT shared by uart_rx and uart_tx.
// Ports: none (package).
package uart_pkg;

  // 50 MHz / 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4,
    PARITY    = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-side signal bundle between serial line, uart_rx and the controller
// Purpose: groups the uart_rx line, read handshake and status signals.
// Signals: i_rx (serial line), i_read (consume pulse), o_data[7:0], o_valid,
//          o_frame_err, o_overrun, o_busy, o_parity_err (only with UART_RX_PARITY_EN).
// Modports: slave = receiver (uart_rx), master = line driver / controller side.
// Config macro: UART_RX_PARITY_EN adds o_parity_err.
interface uart_rx_if;
  logic       i_rx;
  logic       i_read;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;

  modport slave (input i_rx, i_read,
                 output o_data, o_valid, o_frame_err, o_overrun, o_busy, o_parity_err);
  modport master (output i_rx, i_read,
                  input o_data, o_valid, o_frame_err, o_overrun, o_busy, o_parity_err);
`else
  modport slave (input i_rx, i_read,
                 output o_data, o_valid, o_frame_err, o_overrun, o_busy);
  modport master (output i_rx, i_read,
                  input o_data, o_valid, o_frame_err, o_overrun, o_busy);
`endif
endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-time counter producing one sample strobe per bit time
// Purpose: counts 0..CLKS_PER_BIT-1 and wraps, asserting o_tick on the last count.
// Ports: clk, reset (async, active-high), i_restart (reload counter),
//        i_half (with i_restart: first tick after CLKS_PER_BIT/2 cycles), o_tick (sample strobe).
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  input  logic i_half,
  output logic o_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  // Loading here puts the next tick exactly CLKS_PER_BIT/2 cycles after the restart edge.
  localparam logic [W-1:0] HALF_LOAD = W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == LAST);
    if (i_restart) begin
      cnt_d = i_half ? HALF_LOAD : '0;
    end else if (o_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 serial receiver with one-entry holding register
// Purpose: synchronizes i_rx, frames LSB-first characters, holds the byte until read,
//          flags framing errors (pulse) and overruns (sticky until read).
// Ports: clk, reset (async, active-high), bus (uart_rx_if.slave):
//        i_rx, i_read in; o_data, o_valid, o_frame_err, o_overrun, o_busy out.
// Config macro: UART_RX_PARITY_EN adds an even-parity bit and o_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  uart_state_e state_q, state_d;
  logic       sync1_q, rx_s;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       tick;
`ifdef UART_RX_PARITY_EN
  logic       parity_bad_q, parity_bad_d;
  logic       parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer, idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= bus.i_rx;
      rx_s    <= sync1_q;
    end
  end

  // Held in half-bit reload while idle so the first tick lands at start-bit mid-point.
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .reset     (reset),
    .i_restart (state_q == IDLE),
    .i_half    (1'b1),
    .o_tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    if (bus.i_read && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          // Even parity: data plus parity bit must hold an even number of ones.
          parity_bad_d = ^{shift_q, rx_s};
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_q;
`endif
          if (rx_s) begin
            // A read in this same cycle frees the holding register for the new byte.
            if (!valid_q || bus.i_read) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with CLKS_PER_BIT=8
module tb_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int fe0;
  always @(posedge clk) if (bus.o_frame_err) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
  int pe_cnt = 0;
  int pe0;
  always @(posedge clk) if (bus.o_parity_err) pe_cnt <= pe_cnt + 1;
`endif

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       bad_par;
    logic       rd_at_stop;
    logic       read_after;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the first ncyc cycles of a frame; i_read pulses in the cycle of the stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par,
                            input logic rd_at_stop, input int ncyc);
    logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, (^b) ^ bad_par, b, 1'b0};
`else
    // no parity bit on the line, so a parity request has no effect
    bits = {stop ^ (bad_par & 1'b0), b, 1'b0};
`endif
    for (int k = 0; k < ncyc; k++) begin
      bus.i_rx   = bits[k / CPB];
      bus.i_read = rd_at_stop && (k == FRAME - 2);
      @(posedge clk);
      #1;
    end
    bus.i_read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic busy_all;

    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
    vecs[2]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[3]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 0};
    vecs[4]  = '{8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 0};
    vecs[5]  = '{8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 0};
    vecs[6]  = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 0};
    vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[8]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    vecs[9]  = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 0};
    vecs[10] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 0};

    bus.i_rx   = 1'b1;
    bus.i_read = 1'b0;
    reset      = 1'b1;
    tick(3);
    check("reset_data",  bus.o_data, 8'h00);
    check("reset_valid", bus.o_valid, 1'b0);
    check("reset_fe",    bus.o_frame_err, 1'b0);
    check("reset_ovr",   bus.o_overrun, 1'b0);
    check("reset_busy",  bus.o_busy, 1'b0);
    reset = 1'b0;
    tick(4);

    for (int i = 0; i < 11; i++) begin
      fe0 = fe_cnt;
`ifdef UART_RX_PARITY_EN
      pe0 = pe_cnt;
`endif
      send_frame(vecs[i].b, vecs[i].stop, vecs[i].bad_par, vecs[i].rd_at_stop, FRAME);
      bus.i_rx = 1'b1;
      tick(6);
      check($sformatf("v%0d_data", i),  bus.o_data, vecs[i].exp_data);
      check($sformatf("v%0d_valid", i), bus.o_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_ovr", i),   bus.o_overrun, vecs[i].exp_ovr);
      check($sformatf("v%0d_fe", i),    fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("v%0d_busy", i),  bus.o_busy, 1'b0);
`ifdef UART_RX_PARITY_EN
      check($sformatf("v%0d_pe", i),    pe_cnt - pe0, {31'd0, vecs[i].bad_par});
`endif
      if (vecs[i].read_after) begin
        bus.i_read = 1'b1;
        tick(1);
        bus.i_read = 1'b0;
        check($sformatf("v%0d_read_valid", i), bus.o_valid, 1'b0);
        check($sformatf("v%0d_read_ovr", i),   bus.o_overrun, 1'b0);
      end
      tick(2);
    end

    // o_valid must rise exactly at the stop-bit mid-sample.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, FRAME - 2);
    check("stop_sample_minus1_valid", bus.o_valid, 1'b0);
    check("stop_sample_minus1_busy",  bus.o_busy, 1'b1);
    tick(1);
    check("stop_sample_valid", bus.o_valid, 1'b1);
    check("stop_sample_data",  bus.o_data, 8'h5A);
    check("stop_sample_busy",  bus.o_busy, 1'b0);
    bus.i_rx   = 1'b1;
    bus.i_read = 1'b1;
    tick(1);
    bus.i_read = 1'b0;
    check("stop_sample_read_valid", bus.o_valid, 1'b0);
    tick(4);

    // False start: 3 low cycles only.
    fe0 = fe_cnt;
    bus.i_rx = 1'b0;
    tick(3);
    check("false_start_busy_hi", bus.o_busy, 1'b1);
    bus.i_rx = 1'b1;
    tick(8);
    check("false_start_busy", bus.o_busy, 1'b0);
    check("false_start_valid", bus.o_valid, 1'b0);
    check("false_start_fe", fe_cnt - fe0, 0);

    // Break: stop bit 0, line held low for 40 more cycles.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, FRAME);
    busy_all = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (!bus.o_busy) busy_all = 1'b0;
    end
    check("break_busy_held", busy_all, 1'b1);
    check("break_fe_pulses", fe_cnt - fe0, 1);
    check("break_valid", bus.o_valid, 1'b0);
    bus.i_rx = 1'b1;
    tick(4);
    check("break_release_busy", bus.o_busy, 1'b0);
    tick(20);
    check("break_no_new_frame_busy", bus.o_busy, 1'b0);
    check("break_no_new_frame_valid", bus.o_valid, 1'b0);

    // Reset during DATA with a held byte and overrun pending.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, FRAME);
    bus.i_rx = 1'b1;
    tick(3);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, FRAME);
    bus.i_rx = 1'b1;
    tick(3);
    check("pre_reset_ovr", bus.o_overrun, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, CPB * 4);
    check("pre_reset_busy", bus.o_busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_data",  bus.o_data, 8'h00);
    check("midreset_valid", bus.o_valid, 1'b0);
    check("midreset_ovr",   bus.o_overrun, 1'b0);
    check("midreset_fe",    bus.o_frame_err, 1'b0);
    check("midreset_busy",  bus.o_busy, 1'b0);
    bus.i_rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, FRAME);
    bus.i_rx = 1'b1;
    tick(4);
    check("post_reset_data",  bus.o_data, 8'h0F);
    check("post_reset_valid", bus.o_valid, 1'b1);
    check("post_reset_ovr",   bus.o_overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
